// File: rtl/fetch_pkg.sv
// Shared fetch-path types and defaults.
// Imported by fetch_fifo and fetch_queue.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned DEF_DEPTH = 4;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular storage for fetched words.
// Clear empties it; push/pop may coincide.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  fetch_entry_t                 data_i,
  output fetch_entry_t                 data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t      mem_q [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + PW'(1);
      if (pop_i)  head_q <= head_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[tail_q] <= data_i;
  end

  assign data_o  = mem_q[head_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue with credit-based issue and redirect flush.
// Define FETCH_QUEUE_STATS_EN to add the starve_cnt output.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = DEF_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc4
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]     starve_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [CW-1:0]   count;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW:0]     used;
  logic            accept, live_rsp, push, pop;
  fetch_entry_t    wentry, head;

  assign used     = {1'b0, count} + {1'b0, out_q};
  assign imem_req_valid = reset && !redirect_valid
                       && (used < (CW+1)'(DEPTH));
  assign accept   = imem_req_valid && imem_req_ready;
  assign live_rsp = imem_rsp_valid && (drop_q == '0);
  assign push     = live_rsp && !redirect_valid;
  assign pop      = out_valid && out_ready && !redirect_valid;
  assign wentry   = '{instr: imem_rsp_data,
                      pc4:   rsp_pc_q + 32'd4};

  // Live in-flight words become drops on redirect.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      out_d    = '0;
      drop_d   = out_q + drop_q - CW'(imem_rsp_valid);
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (live_rsp) rsp_pc_d = rsp_pc_q + 32'd4;
      if (imem_rsp_valid && drop_q != '0)
        drop_d = drop_q - CW'(1);
      case ({accept, live_rsp})
        2'b10:   out_d = out_q + CW'(1);
        2'b01:   out_d = out_q - CW'(1);
        default: out_d = out_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (wentry),
    .data_o  (head),
    .count_o (count)
  );

  assign imem_addr = pc_q;
  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc4   = head.pc4;

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] starve_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (!out_valid && starve_q != 32'hFFFF_FFFF) begin
      starve_q <= starve_q + 32'd1;
    end
  end

  assign starve_cnt = starve_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed table, corner sequences and
// randomized traffic against a request/epoch reference model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] starve_cnt;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc4        (out_pc4)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .starve_cnt     (starve_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    int          ep;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  typedef struct {
    bit          rr;
    bit          orr;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_ov;
    logic [31:0] e_pc4;
  } vec_t;

  req_t        memq[$];
  ent_t        expq[$];
  logic [31:0] poplog[$];
  logic [31:0] mpc;
  int          epoch;
  int          acc_cnt;

  bit          req_rdy_v, out_rdy_v, redir_v;
  logic [31:0] redir_pc_v;
  int          rsp_pct;

  logic        cap_rv, cap_ov;
  logic [31:0] cap_addr, cap_pc4;

  function automatic logic [31:0] fdata(logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    int   live;
    logic s_acc, s_rsp, s_pop;
    req_t r;
    @(negedge clk);
    reset          = 1'b1;
    imem_req_ready = req_rdy_v;
    out_ready      = out_rdy_v;
    redirect_valid = redir_v;
    redirect_pc    = redir_pc_v;
    imem_rsp_valid = (memq.size() > 0)
                  && ($urandom_range(99) < rsp_pct);
    imem_rsp_data  = (memq.size() > 0) ? fdata(memq[0].addr) : '0;
    #1;
    live = 0;
    foreach (memq[i]) if (memq[i].ep == epoch) live++;
    chk("out_valid", {31'b0, out_valid}, {31'b0, expq.size() != 0});
    if (expq.size() != 0) begin
      chk("out_instr", out_instr, expq[0].instr);
      chk("out_pc4", out_pc4, expq[0].pc4);
    end
    chk("imem_addr", imem_addr, mpc);
    chk("req_valid", {31'b0, imem_req_valid},
        {31'b0, !redir_v && (expq.size() + live < DEPTH)});
    cap_rv   = imem_req_valid;
    cap_ov   = out_valid;
    cap_addr = imem_addr;
    cap_pc4  = out_pc4;
    s_acc = imem_req_valid && imem_req_ready;
    s_rsp = imem_rsp_valid;
    s_pop = out_valid && out_ready && !redir_v;
    @(posedge clk);
    if (s_pop && expq.size() > 0) begin
      poplog.push_back(expq[0].pc4);
      void'(expq.pop_front());
    end
    if (s_rsp) begin
      r = memq.pop_front();
      if (r.ep == epoch && !redir_v)
        expq.push_back('{instr: fdata(r.addr), pc4: r.addr + 32'd4});
    end
    if (s_acc) begin
      memq.push_back('{addr: mpc, ep: epoch});
      mpc = mpc + 32'd4;
      acc_cnt++;
    end
    if (redir_v) begin
      expq.delete();
      epoch++;
      mpc = redir_pc_v;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset          = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_addr", imem_addr, RPC);
    memq.delete();
    expq.delete();
    poplog.delete();
    mpc = RPC;
    epoch++;
    redir_v = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_pop(string name, logic [31:0] exp);
    int n;
    n = 0;
    while (poplog.size() == 0 && n < 30) begin
      step();
      n++;
    end
    chk({name, "_seen"}, {31'b0, poplog.size() != 0}, 32'd1);
    if (poplog.size() != 0) chk(name, poplog[0], exp);
  endtask

  vec_t tbl[6];

  initial begin
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    out_ready = 1'b0;
    mpc = RPC;
    epoch = 0;
    acc_cnt = 0;
    req_rdy_v = 1'b1;
    out_rdy_v = 1'b1;
    redir_v = 1'b0;
    redir_pc_v = '0;
    rsp_pct = 100;

    tbl[0] = '{1, 1, 1, 32'd0,  0, 32'd0};
    tbl[1] = '{1, 1, 1, 32'd4,  0, 32'd0};
    tbl[2] = '{1, 1, 1, 32'd8,  1, 32'd4};
    tbl[3] = '{1, 1, 1, 32'd12, 1, 32'd8};
    tbl[4] = '{1, 1, 1, 32'd16, 1, 32'd12};
    tbl[5] = '{1, 1, 1, 32'd20, 1, 32'd16};

    repeat (2) @(posedge clk);
    #1;
    chk("init_out_valid", {31'b0, out_valid}, 32'd0);
    chk("init_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("init_addr", imem_addr, RPC);

    // Streaming from reset, one-cycle memory.
    for (int i = 0; i < 6; i++) begin
      req_rdy_v = tbl[i].rr;
      out_rdy_v = tbl[i].orr;
      step();
      chk("tbl_rv", {31'b0, cap_rv}, {31'b0, tbl[i].e_rv});
      chk("tbl_addr", cap_addr, tbl[i].e_addr);
      chk("tbl_ov", {31'b0, cap_ov}, {31'b0, tbl[i].e_ov});
      if (tbl[i].e_ov) chk("tbl_pc4", cap_pc4, tbl[i].e_pc4);
    end

    // Back-pressure: credits cap accepted requests at DEPTH.
    do_reset();
    out_rdy_v = 1'b0;
    req_rdy_v = 1'b1;
    rsp_pct = 100;
    acc_cnt = 0;
    repeat (10) step();
    chk("bp_accepts", acc_cnt, DEPTH);
    chk("bp_req_valid", {31'b0, cap_rv}, 32'd0);
    out_rdy_v = 1'b1;
    repeat (6) step();
    chk("bp_pops", {31'b0, poplog.size() >= 4}, 32'd1);
    if (poplog.size() >= 4) begin
      chk("bp_pop0", poplog[0], RPC + 32'd4);
      chk("bp_pop1", poplog[1], RPC + 32'd8);
      chk("bp_pop2", poplog[2], RPC + 32'd12);
      chk("bp_pop3", poplog[3], RPC + 32'd16);
    end

    // Redirect with two requests in flight.
    do_reset();
    rsp_pct = 0;
    req_rdy_v = 1'b1;
    out_rdy_v = 1'b1;
    repeat (2) step();
    req_rdy_v = 1'b0;
    redir_v = 1'b1;
    redir_pc_v = 32'h0000_0100;
    step();
    redir_v = 1'b0;
    rsp_pct = 100;
    req_rdy_v = 1'b1;
    step();
    chk("redir_empty", {31'b0, cap_ov}, 32'd0);
    poplog.delete();
    wait_pop("redir_pc4", 32'h0000_0104);

    // Redirect with full credit, response and pop in the same cycle.
    do_reset();
    rsp_pct = 100;
    req_rdy_v = 1'b1;
    out_rdy_v = 1'b0;
    repeat (4) step();
    redir_v = 1'b1;
    redir_pc_v = 32'h0000_0200;
    out_rdy_v = 1'b1;
    step();
    redir_v = 1'b0;
    step();
    chk("coinc_empty", {31'b0, cap_ov}, 32'd0);
    poplog.delete();
    wait_pop("coinc_pc4", 32'h0000_0204);

    // Asynchronous reset with three entries queued.
    do_reset();
    rsp_pct = 100;
    req_rdy_v = 1'b1;
    out_rdy_v = 1'b0;
    repeat (4) step();
    chk("pre_rst_ov", {31'b0, cap_ov}, 32'd1);
    do_reset();
    out_rdy_v = 1'b1;
    step();
    chk("restart_addr", cap_addr, RPC);
    chk("restart_rv", {31'b0, cap_rv}, 32'd1);

`ifdef FETCH_QUEUE_STATS_EN
    do_reset();
    req_rdy_v = 1'b0;
    out_rdy_v = 1'b0;
    repeat (5) step();
    #1;
    chk("starve_cnt", starve_cnt, 32'd5);
`endif

    // Randomized traffic against the model.
    do_reset();
    rsp_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      req_rdy_v = ($urandom_range(0, 3) != 0);
      out_rdy_v = ($urandom_range(0, 3) != 0);
      redir_v = ($urandom_range(0, 19) == 0) && (memq.size() < DEPTH);
      redir_pc_v = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8
                                               : ($urandom & 32'hFFFF_FFFC);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 redirect_valid  input  1  branch/jump/jr taken this cycle.
REQ-006 redirect_pc  input  32  new fetch target.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_addr  output  32  fetch address.
REQ-010 imem_rsp_valid  input  1  instruction word returned, in request order.
REQ-011 imem_rsp_data  input  32  returned instruction word.
REQ-012 out_valid  output  1  head entry valid toward IF/ID.
REQ-013 out_ready  input  1  IF/ID write enable; pop when out_valid and out_ready.
REQ-014 out_instr  output  32  head instruction.
REQ-015 out_pc4  output  32  head instruction address + 4.

Function
REQ-016 Fetch pointer pc SHALL advance by 4 (mod 2^32) on each accepted request (imem_req_valid and imem_req_ready).
REQ-017 imem_req_valid SHALL be 1 only when count + outstanding < DEPTH and redirect_valid is 0.
REQ-018 imem_addr SHALL equal pc and SHALL stay stable while imem_req_valid is 1 and imem_req_ready is 0.
REQ-019 outstanding SHALL increment on accept, decrement on each response, and be unchanged when both occur together.
REQ-020 A response with drop_cnt = 0 SHALL push {imem_rsp_data, rsp_pc + 4}, then rsp_pc advances by 4.
REQ-021 A response with drop_cnt > 0 SHALL be discarded, and drop_cnt SHALL decrement.
REQ-022 Push-to-out_valid latency SHALL be 1 cycle; there is no combinational fall-through.
REQ-023 out_valid SHALL equal (count != 0); out_instr and out_pc4 SHALL be the head entry.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; credit accounting (REQ-017) guarantees no overflow at full.
REQ-025 On redirect_valid, at the next edge:
- count SHALL become 0.
- pc and rsp_pc SHALL become redirect_pc.
- drop_cnt SHALL become (outstanding + drop_cnt) minus any response arriving in the same cycle.
- No request issues in that cycle.
REQ-026 Redirect SHALL take priority over a same-cycle pop, push or accept; a same-cycle response SHALL count as dropped.
REQ-027 Redirects on back-to-back cycles SHALL each apply; the last target wins.

Reset
REQ-028 While reset = 0:
- count, outstanding and drop_cnt SHALL be 0.
- pc and rsp_pc SHALL be RESET_PC.
- out_valid and imem_req_valid SHALL be 0.
- imem_addr SHALL be RESET_PC.
REQ-029 Reset asserted mid-operation SHALL discard all queued and in-flight state immediately; the memory side SHALL NOT return responses for pre-reset requests.
REQ-030 The first request SHALL be issued in the first cycle after reset deassertion.

Configuration
REQ-031 With FETCH_QUEUE_STATS_EN defined, output starve_cnt (32 bits) SHALL count cycles with out_valid = 0 and reset = 1. It SHALL saturate at 32'hFFFF_FFFF and reset to 0.
REQ-032 Without FETCH_QUEUE_STATS_EN, port starve_cnt and its logic SHALL be absent.

Structure
REQ-033 Package fetch_pkg SHALL hold XLEN = 32, the default DEPTH, RESET_PC, and typedef fetch_entry_t {instr, pc4}.
REQ-034 Sub-module fetch_fifo SHALL implement the storage: head/tail pointers, count, push, pop and clear.
REQ-035 Counter widths SHALL be $clog2(DEPTH+1).

Verification
REQ-036 Reset release, imem_req_ready = 1, rsp 1 cycle later, out_ready = 1 -> addrs 0,4,8..., out_pc4 4,8,12..., one instruction per cycle after fill.
REQ-037 out_ready = 0 for 10 cycles, DEPTH = 4 -> exactly 4 requests accepted, imem_req_valid = 0 thereafter, no loss on release.
REQ-038 Two requests outstanding, redirect_pc = 32'h0000_0100 -> both responses dropped, next out_pc4 = 32'h0000_0104, queue empty one cycle after redirect.
REQ-039 Redirect coincident with response, pop and a full queue -> queue empty, response dropped, drop_cnt consistent, no duplicate or lost instruction.
REQ-040 reset pulsed low mid-stream with 3 queued -> out_valid = 0 asynchronously, fetch restarts at RESET_PC.
REQ-041 FETCH_QUEUE_STATS_EN defined, 5 empty cycles after reset -> starve_cnt = 5.
